// File: rtl/dvp_capture_pkg.sv
// rtl/dvp_capture_pkg.sv - shared FSM encoding and FIFO tag layout for the DVP capture block
package dvp_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DROP    = 2'd3
  } cap_state_t;

  // FIFO word layout: {pixel, sop, eol}
  localparam int TAG_EOL  = 0;
  localparam int TAG_SOP  = 1;
  localparam int TAG_BITS = 2;

endpackage

// File: rtl/dvp_capture_fifo.sv
// rtl/dvp_capture_fifo.sv - generic first-word fall-through synchronous FIFO
module dvp_capture_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/dvp_capture_stream.sv
// rtl/dvp_capture_stream.sv - DVP camera capture to pixel stream; DVP_CAPTURE_CROP_EN adds a crop window
module dvp_capture_stream
  import dvp_capture_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int FIFO_DEPTH      = 16,
  parameter int LINE_BITS       = 11
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  dvp_pclk,
  input  logic [DATA_WIDTH-1:0]                 dvp_data,
  input  logic                                  dvp_href,
  input  logic                                  dvp_vsync,
  input  logic                                  enable,
  input  logic                                  ovf_clear,
`ifdef DVP_CAPTURE_CROP_EN
  input  logic [LINE_BITS-1:0]                  crop_x0,
  input  logic [LINE_BITS-1:0]                  crop_x1,
  input  logic [LINE_BITS-1:0]                  crop_y0,
  input  logic [LINE_BITS-1:0]                  crop_y1,
`endif
  output logic [BYTES_PER_PIXEL*DATA_WIDTH-1:0] st_data,
  output logic                                  st_sop,
  output logic                                  st_eol,
  output logic                                  st_valid,
  input  logic                                  st_ready,
  output logic                                  frame_done,
  output logic                                  overflow,
  output logic [LINE_BITS-1:0]                  line_count,
  output logic                                  busy
);

  localparam int PIX_W = BYTES_PER_PIXEL * DATA_WIDTH;
  localparam int FW    = PIX_W + TAG_BITS;

  logic                  pclk_s1, pclk_s2, pclk_s3;
  logic                  href_s1, href_s2, href_s3;
  logic                  vsync_s1, vsync_s2, vsync_s3;
  logic [DATA_WIDTH-1:0] data_d1, data_d2;

  cap_state_t            state;
  logic                  beat_idx, beat_cur, last_beat;
  logic                  cap, pix_done, pix_fwd, in_win;
  logic [PIX_W-1:0]      pix_val;
  logic                  stg_valid, stg_sop, sop_pend;
  logic [PIX_W-1:0]      stg_data;
  logic [LINE_BITS-1:0]  line_cnt;
  logic                  fd_pend;

  logic                  push_req, pop, drop, fifo_full, fifo_empty;
  logic [FW-1:0]         push_word, pop_word;

  wire pclk_rise = pclk_s2 & ~pclk_s3;
  wire href_rise = href_s2 & ~href_s3;
  wire href_fall = ~href_s2 & href_s3;
  wire vs_fall   = ~vsync_s2 & vsync_s3;
  wire vs_rise   = vsync_s2 & ~vsync_s3;

  assign cap       = pclk_rise & href_s2 & (state == ST_ACTIVE);
  // A beat coinciding with the HREF rise is already the first beat of the line.
  assign beat_cur  = href_rise ? 1'b0 : beat_idx;
  assign last_beat = (beat_cur == 1'(BYTES_PER_PIXEL - 1));
  assign pix_done  = cap & last_beat;
  assign pix_fwd   = pix_done & in_win;

  generate
    if (BYTES_PER_PIXEL == 2) begin : g_pack2
      logic [DATA_WIDTH-1:0] acc;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               acc <= '0;
        else if (cap && !last_beat) acc <= data_d2;
      end
      assign pix_val = {acc, data_d2};
    end else begin : g_pack1
      assign pix_val = data_d2;
    end
  endgenerate

`ifdef DVP_CAPTURE_CROP_EN
  logic [LINE_BITS-1:0] px_idx, px_cur;
  logic [LINE_BITS-1:0] win_x0, win_x1, win_y0, win_y1;

  assign px_cur = href_rise ? '0 : px_idx;
  assign in_win = (px_cur >= win_x0) && (px_cur <= win_x1) &&
                  (line_cnt >= win_y0) && (line_cnt <= win_y1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px_idx <= '0;
      win_x0 <= '0;
      win_x1 <= '0;
      win_y0 <= '0;
      win_y1 <= '0;
    end else begin
      if (href_rise) px_idx <= '0;
      if (pix_done)  px_idx <= px_cur + 1'b1;
      if (state == ST_WAIT_VS && vs_fall) begin
        win_x0 <= crop_x0;
        win_x1 <= crop_x1;
        win_y0 <= crop_y0;
        win_y1 <= crop_y1;
      end
    end
  end
`else
  assign in_win = 1'b1;
`endif

  // The staged pixel leaves when its successor completes, or with eol at the line end.
  always_comb begin
    push_req  = 1'b0;
    push_word = '0;
    if (state == ST_ACTIVE && stg_valid && (href_fall || pix_fwd)) begin
      push_req                = 1'b1;
      push_word[FW-1:TAG_BITS] = stg_data;
      push_word[TAG_SOP]      = stg_sop;
      push_word[TAG_EOL]      = href_fall;
    end
  end

  assign pop  = ~fifo_empty & st_ready;
  assign drop = push_req & fifo_full & ~pop;

  dvp_capture_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .wdata   (push_word),
    .pop     (pop),
    .rdata   (pop_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign st_data  = pop_word[FW-1:TAG_BITS];
  assign st_sop   = pop_word[TAG_SOP];
  assign st_eol   = pop_word[TAG_EOL];
  assign st_valid = ~fifo_empty;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      {pclk_s1, pclk_s2, pclk_s3}    <= '0;
      {href_s1, href_s2, href_s3}    <= '0;
      {vsync_s1, vsync_s2, vsync_s3} <= '0;
      data_d1    <= '0;
      data_d2    <= '0;
      state      <= ST_IDLE;
      beat_idx   <= 1'b0;
      stg_valid  <= 1'b0;
      stg_sop    <= 1'b0;
      stg_data   <= '0;
      sop_pend   <= 1'b0;
      line_cnt   <= '0;
      line_count <= '0;
      fd_pend    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      {pclk_s1, pclk_s2, pclk_s3}    <= {dvp_pclk, pclk_s1, pclk_s2};
      {href_s1, href_s2, href_s3}    <= {dvp_href, href_s1, href_s2};
      {vsync_s1, vsync_s2, vsync_s3} <= {dvp_vsync, vsync_s1, vsync_s2};
      data_d1    <= dvp_data;
      data_d2    <= data_d1;
      fd_pend    <= 1'b0;
      frame_done <= fd_pend;

      if (drop)           overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;

      if (href_rise || href_fall) beat_idx <= 1'b0;
      if (cap)                    beat_idx <= last_beat ? 1'b0 : ~beat_cur;

      case (state)
        ST_IDLE: begin
          if (enable) state <= ST_WAIT_VS;
        end
        ST_WAIT_VS: begin
          if (vs_fall) begin
            state     <= ST_ACTIVE;
            line_cnt  <= '0;
            stg_valid <= 1'b0;
            sop_pend  <= 1'b1;
          end
        end
        ST_ACTIVE, ST_DROP: begin
          if (state == ST_ACTIVE) begin
            if (pix_fwd) begin
              stg_valid <= 1'b1;
              stg_data  <= pix_val;
              stg_sop   <= sop_pend;
              sop_pend  <= 1'b0;
            end
            if (href_fall) begin
              stg_valid <= 1'b0;
              if (line_cnt != '1) line_cnt <= line_cnt + 1'b1;
            end
            if (drop) state <= ST_DROP;
          end
          if (vs_rise) begin
            line_count <= line_cnt;
            fd_pend    <= 1'b1;
            stg_valid  <= 1'b0;
            state      <= enable ? ST_WAIT_VS : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
